// File: rtl/pc_fetch_ctrl.sv
// Purpose: owns the architectural PC and sequences single-outstanding instruction fetches to decode.
// Latency: request, response and delivery take one cycle each; 0-wait memory yields one instruction per 3 cycles.
// Backpressure: stall holds the delivered instruction and blocks new requests; imem_req_ready gates request issue.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    // S_DROP: a request is in flight whose response must be thrown away.
    // S_HALT: a misaligned redirect was seen; only reset leaves this state.
    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] inst_pc_nxt;
    logic [31:0] fetch_cnt_nxt;
    logic        inst_valid_nxt;
    logic        misalign_nxt;
    logic        accept;
    logic        bad_target;

    // Request is a pure decode of the state so the memory never sees a combinational loop.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign bad_target     = redirect_valid & (redirect_target[1:0] != 2'b00);

    // State and datapath registers; reset also aborts any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            misalign   <= 1'b0;
            fetch_cnt  <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_valid <= inst_valid_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            misalign   <= misalign_nxt;
            fetch_cnt  <= fetch_cnt_nxt;
        end
    end

    // Next-state and datapath update; redirect outranks stall and any same-cycle response.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_valid_nxt = inst_valid;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        misalign_nxt   = misalign;
        fetch_cnt_nxt  = fetch_cnt;

        if (bad_target && (state != S_HALT)) begin
            misalign_nxt   = 1'b1;
            pc_nxt         = redirect_target;
            inst_valid_nxt = 1'b0;
            state_nxt      = S_HALT;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_nxt = redirect_target;
                    end
                    if (accept) begin
                        state_nxt = redirect_valid ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_nxt    = redirect_target;
                        state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        inst_nxt       = imem_rsp_data;
                        inst_pc_nxt    = pc;
                        pc_nxt         = pc + 32'd4;
                        inst_valid_nxt = 1'b1;
                        state_nxt      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_nxt         = redirect_target;
                        inst_valid_nxt = 1'b0;
                        state_nxt      = S_REQ;
                    end else if (!stall) begin
                        fetch_cnt_nxt  = fetch_cnt + 32'd1;
                        inst_valid_nxt = 1'b0;
                        state_nxt      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        pc_nxt = redirect_target;
                    end
                    if (imem_rsp_valid) begin
                        state_nxt = S_REQ;
                    end
                end
                S_HALT: begin
                    inst_valid_nxt = 1'b0;
                end
                default: begin
                    state_nxt = S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with constant expectations, then random traffic
// against a transaction-level reference model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int passed = 0;

    // memory responder state
    bit          mem_auto = 1'b0;
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'h0;

    // reference model state
    logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
    bit          m_misalign, m_have, m_busy, m_discard, m_halted;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .pc              (pc),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .misalign        (misalign),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle; outputs are settled 2 time units after the edge.
    task automatic tick();
        bit          acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready && rst_n && mem_auto;
        a   = imem_req_addr;
        @(posedge clk);
        #2;
        imem_rsp_valid = 1'b0;
        if (!mem_auto || !rst_n) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = a;
        end
        if (mem_auto && mem_pend) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memfn(mem_addr);
                mem_pend       = 1'b0;
            end
        end
    endtask

    // Transaction view: requesting, awaiting a response (kept or discarded), holding an instruction, halted.
    task automatic model_step(input bit rst, input bit rv, input logic [31:0] rt, input bit st,
                              input bit rdy, input bit rsp, input logic [31:0] dat);
        bit req;
        req = !m_halted && !m_have && !m_busy;
        if (!rst) begin
            m_pc = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0; m_cnt = 32'h0;
            m_misalign = 0; m_have = 0; m_busy = 0; m_discard = 0; m_halted = 0;
        end else if (m_halted) begin
            // only reset leaves the halted condition
        end else if (rv && rt[1:0] != 2'b00) begin
            m_misalign = 1; m_pc = rt; m_have = 0; m_busy = 0; m_halted = 1;
        end else if (m_have) begin
            if (rv) begin
                m_have = 0; m_pc = rt;
            end else if (!st) begin
                m_have = 0; m_cnt = m_cnt + 32'd1;
            end
        end else if (m_busy) begin
            if (rsp) begin
                if (!m_discard && !rv) begin
                    m_inst = dat; m_inst_pc = m_pc; m_pc = m_pc + 32'd4; m_have = 1;
                end
                if (rv) m_pc = rt;
                m_busy = 0; m_discard = 0;
            end else if (rv) begin
                m_pc = rt; m_discard = 1;
            end
        end else if (req) begin
            if (rv) m_pc = rt;
            if (rdy) begin
                m_busy = 1; m_discard = rv;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({pc, inst_valid, inst, inst_pc, misalign, fetch_cnt, imem_req_valid, imem_req_addr} !==
            {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0})
            $display("FAIL reset_state pc=%h iv=%b inst=%h ipc=%h mis=%b cnt=%0d rv=%b ra=%h required all zero with req_valid=1",
                     pc, inst_valid, inst, inst_pc, misalign, fetch_cnt, imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    task automatic test_sequential();
        rst_n = 1'b1; mem_auto = 1'b1; mem_lat = 1; imem_req_ready = 1'b1; stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!(imem_req_valid === 1'b1 && imem_req_addr === 32'(4 * k)))
                $display("FAIL seq_req%0d valid=%b addr=%h required 1/%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
            else passed++;
            tick();
            checks++;
            if (inst_valid !== 1'b0) $display("FAIL seq_wait%0d inst_valid=%b required 0", k, inst_valid);
            else passed++;
            tick();
            checks++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 32'(4 * k), memfn(32'(4 * k))})
                $display("FAIL seq_hold%0d iv=%b ipc=%h inst=%h required 1/%h/%h", k, inst_valid, inst_pc, inst,
                         32'(4 * k), memfn(32'(4 * k)));
            else passed++;
            tick();
        end
        checks++;
        if (fetch_cnt !== 32'd3) $display("FAIL seq_count fetch_cnt=%0d required 3", fetch_cnt);
        else passed++;
    endtask

    task automatic test_stall();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick(); tick();   // instruction at 0x0 consumed
        tick();                   // request 0x4 accepted
        stall = 1'b1;
        tick();                   // response delivered into hold
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({inst_valid, inst, inst_pc, imem_req_valid, fetch_cnt} !== {1'b1, 32'h0050_0093, 32'h4, 1'b0, 32'd1})
                $display("FAIL stall_hold%0d iv=%b inst=%h ipc=%h rv=%b cnt=%0d required 1/00500093/4/0/1",
                         i, inst_valid, inst, inst_pc, imem_req_valid, fetch_cnt);
            else passed++;
            tick();
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({fetch_cnt, inst_valid, imem_req_valid, imem_req_addr} !== {32'd2, 1'b0, 1'b1, 32'h8})
            $display("FAIL stall_release cnt=%0d iv=%b rv=%b ra=%h required 2/0/1/8",
                     fetch_cnt, inst_valid, imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    task automatic test_redirect_wait();
        mem_auto = 1'b0;
        tick();                   // request 0x8 accepted, no auto response
        redirect_valid = 1'b1; redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({pc, imem_req_valid} !== {32'h100, 1'b0})
            $display("FAIL rdw_drop pc=%h rv=%b required 100/0", pc, imem_req_valid);
        else passed++;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
        tick();
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL rdw_discard iv=%b rv=%b ra=%h required 0/1/100", inst_valid, imem_req_valid, imem_req_addr);
        else passed++;
        mem_auto = 1'b1;
        tick(); tick();
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, memfn(32'h100)})
            $display("FAIL rdw_deliver iv=%b ipc=%h inst=%h required 1/100/%h", inst_valid, inst_pc, inst, memfn(32'h100));
        else passed++;
        tick();                   // consumed, pc now 0x104
    endtask

    task automatic test_redirect_with_rsp();
        mem_auto = 1'b0;
        tick();                   // request 0x104 accepted
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr, inst} !== {1'b0, 1'b1, 32'h200, memfn(32'h100)})
            $display("FAIL rdr_same iv=%b rv=%b ra=%h inst=%h required 0/1/200/%h",
                     inst_valid, imem_req_valid, imem_req_addr, inst, memfn(32'h100));
        else passed++;
    endtask

    task automatic test_misalign();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        checks++;
        if ({misalign, pc, imem_req_valid, inst_valid} !== {1'b1, 32'h102, 1'b0, 1'b0})
            $display("FAIL mis_enter mis=%b pc=%h rv=%b iv=%b required 1/102/0/0", misalign, pc, imem_req_valid, inst_valid);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            redirect_valid  = (i % 2) == 0;
            redirect_target = 32'h300 + 32'(4 * i);
            tick();
            imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
            checks++;
            if ({imem_req_valid, misalign, pc, inst_valid} !== {1'b0, 1'b1, 32'h102, 1'b0})
                $display("FAIL mis_halt%0d rv=%b mis=%b pc=%h iv=%b required 0/1/102/0",
                         i, imem_req_valid, misalign, pc, inst_valid);
            else passed++;
        end
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({misalign, pc, imem_req_valid, imem_req_addr} !== {1'b0, 32'h0, 1'b1, 32'h0})
            $display("FAIL mis_reset mis=%b pc=%h rv=%b ra=%h required 0/0/1/0", misalign, pc, imem_req_valid, imem_req_addr);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        mem_auto = 1'b1; mem_lat = 1; imem_req_ready = 1'b1;
        tick(); tick(); tick();   // instruction at 0x0 consumed
        mem_auto = 1'b0;
        tick();                   // request 0x4 in flight
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL rmw_restart rv=%b ra=%h iv=%b required 1/0/0", imem_req_valid, imem_req_addr, inst_valid);
        else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFEED_FEED;
        tick();
        checks++;
        if ({inst_valid, imem_req_valid, pc} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL rmw_ignore iv=%b rv=%b pc=%h required 0/0/0", inst_valid, imem_req_valid, pc);
        else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        tick();
        checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h13, 32'h0})
            $display("FAIL rmw_deliver iv=%b inst=%h ipc=%h required 1/13/0", inst_valid, inst, inst_pc);
        else passed++;
    endtask

    task automatic test_random();
        bit          s_rst, s_rv, s_st, s_rdy, s_rsp;
        logic [31:0] s_rt, s_dat;
        int          r;
        mem_auto = 1'b1;
        for (int run = 0; run < 6; run++) begin
            for (int cyc = 0; cyc < 160; cyc++) begin
                rst_n = (cyc != 0);
                redirect_valid = ($urandom_range(0, 7) == 0);
                r = $urandom_range(0, 59);
                if (r == 0)      redirect_target = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                else if (r < 15) redirect_target = 32'hFFFF_FFFC;
                else             redirect_target = $urandom & 32'hFFFF_FFFC;
                stall          = ($urandom_range(0, 2) == 0);
                imem_req_ready = $urandom_range(0, 1);
                mem_lat        = $urandom_range(1, 3);
                s_rst = rst_n; s_rv = redirect_valid; s_rt = redirect_target; s_st = stall;
                s_rdy = imem_req_ready; s_rsp = imem_rsp_valid; s_dat = imem_rsp_data;
                tick();
                model_step(s_rst, s_rv, s_rt, s_st, s_rdy, s_rsp, s_dat);
                checks++;
                if ({pc, inst_valid, inst, inst_pc, misalign, fetch_cnt, imem_req_valid, imem_req_addr} !==
                    {m_pc, m_have, m_inst, m_inst_pc, m_misalign, m_cnt,
                     !m_halted && !m_have && !m_busy, m_pc})
                    $display("FAIL rand r%0d c%0d pc=%h iv=%b inst=%h ipc=%h mis=%b cnt=%0d rv=%b required pc=%h iv=%b inst=%h ipc=%h mis=%b cnt=%0d rv=%b",
                             run, cyc, pc, inst_valid, inst, inst_pc, misalign, fetch_cnt, imem_req_valid,
                             m_pc, m_have, m_inst, m_inst_pc, m_misalign, m_cnt, !m_halted && !m_have && !m_busy);
                else passed++;
            end
        end
        redirect_valid = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_with_rsp();
        test_misalign();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Owns the architectural PC register and sequences instruction fetch from instruction memory over a valid/ready request and valid response handshake. It delivers one instruction at a time to decode, holds it while the pipeline stalls, and accepts control-flow redirects. Redirect targets come from the next-PC unit's npc output. The block sits between the next-PC unit, the hazard/stall logic and the instruction memory port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
redirect_valid  input  1  taken branch, jal or jalr resolved this cycle; load redirect_target.
redirect_target  input  32  next PC from the next-PC unit (npc).
stall  input  1  decode cannot accept; hold the delivered instruction.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request; transfer when valid & ready.
imem_req_addr  output  32  fetch address; always equals pc.
imem_rsp_valid  input  1  one-cycle pulse carrying read data for the oldest accepted request.
imem_rsp_data  input  32  instruction word.
pc  output  32  current fetch PC.
inst_valid  output  1  inst/inst_pc hold a valid instruction for decode.
inst  output  32  delivered instruction.
inst_pc  output  32  PC of the delivered instruction.
misalign  output  1  sticky; redirect target had bits [1:0] != 0.
fetch_cnt  output  32  count of instructions consumed by decode.

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=S_REQ, inst_valid=0, inst=0, inst_pc=0, misalign=0, fetch_cnt=0. Reset overrides every other input and aborts any in-flight request. A response arriving the cycle after reset is ignored, because the state is S_REQ, not S_WAIT.
- Outputs: imem_req_valid=1 only in S_REQ (decoded from state, no input dependency). imem_req_addr=pc. inst_valid is registered and equals 1 only in S_HOLD.
- At most one outstanding request.
- Redirect priority: redirect_valid beats stall and beats any response in the same cycle.
- Misaligned redirect (redirect_target[1:0]!=0), in any state except S_HALT:
  - misalign<=1, pc<=redirect_target, inst_valid<=0, go to S_HALT.
  - The normal redirect rules below do not apply.
- S_REQ:
  - accept & !redirect -> S_WAIT.
  - accept & redirect -> pc<=target, S_DROP.
  - !accept & redirect -> pc<=target, stay S_REQ.
  - Otherwise hold.
- S_WAIT:
  - rsp_valid & !redirect -> inst<=data, inst_pc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), inst_valid<=1, S_HOLD.
  - rsp_valid & redirect -> discard data, pc<=target, S_REQ.
  - !rsp_valid & redirect -> pc<=target, S_DROP.
- S_HOLD:
  - Consume when !stall: fetch_cnt+=1 (wraps), inst_valid<=0, S_REQ.
  - redirect, with or without stall: no consume, no count, inst_valid<=0, pc<=target, S_REQ.
  - stall & !redirect: hold inst/inst_pc/inst_valid stable.
- S_DROP:
  - rsp_valid -> discard, S_REQ; if redirect in the same cycle, pc<=target as well.
  - !rsp_valid & redirect -> pc<=target, stay S_DROP.
- S_HALT: no requests, inst_valid=0, responses ignored, redirects ignored; exit only by reset.
- Throughput: 0-wait memory gives one instruction per 3 cycles (REQ, WAIT, HOLD). Do not add prefetch.

Test Plan:
- Reset then memory ready=1 with 1-cycle response: addresses 0x0,0x4,0x8 requested. inst_valid rises on cycle 3 with inst_pc=0x0. fetch_cnt=3 after three consumes.
- stall=1 for 5 cycles in S_HOLD with inst=0x00500093: inst, inst_pc=0x4 and inst_valid held constant. No new request. fetch_cnt unchanged until stall drops.
- redirect_valid with target 0x100 while in S_WAIT, response 2 cycles later: that response is discarded and inst_valid stays 0. Next request addr=0x100, then inst_pc=0x100.
- redirect_valid with target 0x200 in the same cycle as imem_rsp_valid: data discarded, next state S_REQ, imem_req_addr=0x200 next cycle.
- redirect_target=0x102: misalign=1, pc=0x102, imem_req_valid stays 0 for 10 cycles despite later redirects. rst_n=0 then clears misalign and restarts fetch at RESET_PC.
- Reset asserted mid S_WAIT, then a response arrives the next cycle: response ignored, first request after reset addr=RESET_PC, inst_valid=0 until the new response.
